// File: rtl/mul_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul_ctrl : RV64 M-extension multiply sequencer for a 64-cycle shift-add   |
// |            unsigned multiplier. MUL_RESULT_CACHE_EN adds a 1-entry cache. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        busy,
    output logic        mul_in_valid,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic        mul_stallreq,
    input  logic [63:0] mul_result_h,
    input  logic [63:0] mul_result_l
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        resp_valid_q;
    logic [63:0] resp_data_q;
    logic        mul_in_valid_q;
    logic [63:0] mul_a_q;
    logic [63:0] mul_b_q;

    logic        accept;
    logic        cache_hit;
    logic [63:0] cache_res;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [63:0] a_src, b_src, a_mag, b_mag;

    // Negating 0x8000_0000_0000_0000 yields itself, which is the correct magnitude 2^63.
    always_comb begin
        a_src    = req_a;
        b_src    = req_b;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (req_op)
            OP_MULH: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            OP_MULW: begin
                a_src = {32'd0, req_a[31:0]};
                b_src = {32'd0, req_b[31:0]};
            end
            default: ;
        endcase
        a_neg = a_signed & a_src[63];
        b_neg = b_signed & b_src[63];
        a_mag = a_neg ? (~a_src + 64'd1) : a_src;
        b_mag = b_neg ? (~b_src + 64'd1) : b_src;
    end

    logic [127:0] prod_raw, prod;
    logic [63:0]  result;

    assign prod_raw = {mul_result_h, mul_result_l};
    assign prod     = neg_q ? (~prod_raw + 128'd1) : prod_raw;

    always_comb begin
        case (op_q)
            OP_MUL:                       result = prod[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[127:64];
            OP_MULW:                      result = {{32{prod[31]}}, prod[31:0]};
            default:                      result = 64'd0;
        endcase
    end

    assign req_ready    = (state_q == S_IDLE) && !flush;
    assign accept       = req_valid && req_ready;
    assign busy         = (state_q != S_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign mul_in_valid = mul_in_valid_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;

`ifdef MUL_RESULT_CACHE_EN
    logic        c_valid_q;
    logic [2:0]  c_op_q;
    logic [63:0] c_a_q, c_b_q, c_res_q;
    logic [63:0] p_a_q, p_b_q;

    assign cache_hit = c_valid_q && (c_op_q == req_op) && (c_a_q == req_a) && (c_b_q == req_b);
    assign cache_res = c_res_q;

    // Raw operands are staged at acceptance so a flushed operation never disturbs the entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid_q <= 1'b0;
            c_op_q    <= 3'd0;
            c_a_q     <= 64'd0;
            c_b_q     <= 64'd0;
            c_res_q   <= 64'd0;
            p_a_q     <= 64'd0;
            p_b_q     <= 64'd0;
        end else begin
            if (accept) begin
                p_a_q <= req_a;
                p_b_q <= req_b;
            end
            if ((state_q == S_DONE) && resp_ready && !flush) begin
                c_valid_q <= 1'b1;
                c_op_q    <= op_q;
                c_a_q     <= p_a_q;
                c_b_q     <= p_b_q;
                c_res_q   <= resp_data_q;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = 64'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= 3'd0;
            neg_q          <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 64'd0;
            mul_in_valid_q <= 1'b0;
            mul_a_q        <= 64'd0;
            mul_b_q        <= 64'd0;
        end else begin
            mul_in_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        if (cache_hit) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= cache_res;
                            state_q      <= S_DONE;
                        end else begin
                            neg_q          <= a_neg ^ b_neg;
                            mul_a_q        <= a_mag;
                            mul_b_q        <= b_mag;
                            mul_in_valid_q <= 1'b1;
                            state_q        <= S_START;
                        end
                    end
                end
                S_START: state_q <= flush ? S_DRAIN : S_WAIT;
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else if (!mul_stallreq) begin
                        resp_data_q  <= result;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (!mul_stallreq) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`timescale 1ns/1ps
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [63:0] req_a = 64'd0;
    logic [63:0] req_b = 64'd0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        busy;
    logic        mul_in_valid;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        mul_stallreq;
    logic [63:0] mul_result_h;
    logic [63:0] mul_result_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_stallreq(mul_stallreq), .mul_result_h(mul_result_h), .mul_result_l(mul_result_l)
    );

    // 64-cycle unsigned multiplier stand-in: stall high for 64 cycles after the start pulse.
    int unsigned  mcnt;
    logic         mstall;
    logic [127:0] mprod;
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt <= 0; mstall <= 1'b0; mprod <= '0;
        end else if (mul_in_valid) begin
            mcnt <= 64; mstall <= 1'b1; mprod <= {64'd0, mul_a} * {64'd0, mul_b};
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1; mstall <= (mcnt != 1);
        end
    end
    assign mul_stallreq = mstall;
    assign {mul_result_h, mul_result_l} = mprod;

`ifdef MUL_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    // Reference: last completed (handshaken) operation, for the optional cache.
    bit          mc_valid = 1'b0;
    logic [2:0]  mc_op;
    logic [63:0] mc_a, mc_b;

    function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (CACHE && mc_valid && mc_op == op && mc_a == a && mc_b == b) return 1;
        return 67;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x, y, p;
        case (op)
            3'd0: begin x = {64'd0, a};         y = {64'd0, b};         p = x * y; return p[63:0];   end
            3'd1: begin x = {{64{a[63]}}, a};   y = {{64{b[63]}}, b};   p = x * y; return p[127:64]; end
            3'd2: begin x = {{64{a[63]}}, a};   y = {64'd0, b};         p = x * y; return p[127:64]; end
            3'd3: begin x = {64'd0, a};         y = {64'd0, b};         p = x * y; return p[127:64]; end
            3'd4: begin x = {96'd0, a[31:0]};   y = {96'd0, b[31:0]};   p = x * y;
                        return {{32{p[31]}}, p[31:0]}; end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0:       return 64'h8000_0000_0000_0000;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'($urandom_range(0, 10));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Presents a request and returns at the negedge of the first resp_valid cycle (cycle = lat).
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic [63:0] data, output int iv_n, output int iv_first);
        int w;
        lat = -1; data = 64'hDEAD_DEAD_DEAD_DEAD; iv_n = 0; iv_first = -1;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (mul_in_valid) begin iv_n++; if (iv_first < 0) iv_first = c; end
            if (resp_valid) begin lat = c; data = resp_data; break; end
            @(negedge clk);
        end
    endtask

    task automatic consume(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        mc_valid = 1'b1; mc_op = op; mc_a = a; mc_b = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (resp_valid !== 1'b0)    begin errors++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
        if (resp_data !== 64'd0)    begin errors++; $display("FAIL reset resp_data: got %h expected 0", resp_data); end
        if (mul_in_valid !== 1'b0)  begin errors++; $display("FAIL reset mul_in_valid: got %b expected 0", mul_in_valid); end
        if (mul_a !== 64'd0)        begin errors++; $display("FAIL reset mul_a: got %h expected 0", mul_a); end
        if (mul_b !== 64'd0)        begin errors++; $display("FAIL reset mul_b: got %h expected 0", mul_b); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        mc_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1)     begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    endtask

    typedef struct { logic [2:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] exp; } vec_t;

    task automatic test_directed();
        vec_t v[5];
        int lat, ivn, ivf, el;
        logic [63:0] d;
        v[0] = '{3'd0, 64'd3, 64'd5, 64'h0000_0000_0000_000F};
        v[1] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        v[2] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        v[3] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        v[4] = '{3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        for (int i = 0; i < 5; i++) begin
            el = exp_lat(v[i].op, v[i].a, v[i].b);
            run_op(v[i].op, v[i].a, v[i].b, lat, d, ivn, ivf);
            checks += 4;
            if (d !== v[i].exp) begin errors++; $display("FAIL directed[%0d] data: got %h expected %h", i, d, v[i].exp); end
            if (lat !== el)     begin errors++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, el); end
            if (ivn !== 1)      begin errors++; $display("FAIL directed[%0d] mul_in_valid count: got %0d expected 1", i, ivn); end
            if (ivf !== 1)      begin errors++; $display("FAIL directed[%0d] mul_in_valid cycle: got %0d expected 1", i, ivf); end
            consume(v[i].op, v[i].a, v[i].b);
        end
    endtask

    task automatic test_random();
        int lat, ivn, ivf, el;
        logic [63:0] a, b, d, e;
        logic [2:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = rnd64(); b = rnd64();
            e = ref_mul(op, a, b);
            el = exp_lat(op, a, b);
            run_op(op, a, b, lat, d, ivn, ivf);
            checks += 2;
            if (d !== e)    begin errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h data: got %h expected %h", i, op, a, b, d, e); end
            if (lat !== el) begin errors++; $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, el); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume(op, a, b);
        end
    endtask

    task automatic test_flush();
        int rr_cyc, st_cyc, rv_seen, w, lat, ivn, ivf;
        logic [63:0] d;
        rr_cyc = -1; st_cyc = -1; rv_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 64'd1234; req_b = 64'd4321;
        w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            flush = (c == 10);
            #1;
            if (resp_valid) rv_seen++;
            if (st_cyc < 0 && c > 1 && !mul_stallreq) st_cyc = c;
            if (rr_cyc < 0 && req_ready) rr_cyc = c;
            if (rr_cyc >= 0) break;
            @(negedge clk);
        end
        flush = 1'b0;
        checks += 2;
        if (rv_seen !== 0)          begin errors++; $display("FAIL flush resp_valid cycles: got %0d expected 0", rv_seen); end
        if (rr_cyc !== st_cyc + 1)  begin errors++; $display("FAIL flush req_ready rise cycle: got %0d expected %0d", rr_cyc, st_cyc + 1); end
        run_op(3'd0, 64'd7, 64'd6, lat, d, ivn, ivf);
        checks += 2;
        if (d !== 64'd42)  begin errors++; $display("FAIL flush next MUL data: got %h expected %h", d, 64'd42); end
        if (lat !== exp_lat(3'd0, 64'd7, 64'd6)) begin errors++; $display("FAIL flush next MUL latency: got %0d", lat); end
        consume(3'd0, 64'd7, 64'd6);
    endtask

    task automatic test_flush_done();
        int lat, ivn, ivf;
        logic [63:0] d;
        run_op(3'd3, 64'd99, 64'd77, lat, d, ivn, ivf);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks += 2;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_done resp_valid: got %b expected 0", resp_valid); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL flush_done busy: got %b expected 0", busy); end
        // flush in IDLE must block acceptance
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 64'd5; req_b = 64'd5;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle req_ready: got %b expected 0", req_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy: got %b expected 0", busy); end
        req_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_hold();
        int lat, ivn, ivf;
        logic [63:0] d, a, b;
        a = rnd64(); b = rnd64();
        run_op(3'd1, a, b, lat, d, ivn, ivf);
        checks++;
        if (d !== ref_mul(3'd1, a, b)) begin errors++; $display("FAIL hold data: got %h expected %h", d, ref_mul(3'd1, a, b)); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks += 3;
            if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold[%0d] resp_valid: got %b expected 1", i, resp_valid); end
            if (resp_data !== d)     begin errors++; $display("FAIL hold[%0d] resp_data: got %h expected %h", i, resp_data, d); end
            if (busy !== 1'b1)       begin errors++; $display("FAIL hold[%0d] busy: got %b expected 1", i, busy); end
        end
        consume(3'd1, a, b);
        checks += 3;
        if (busy !== 1'b0)       begin errors++; $display("FAIL hold after busy: got %b expected 0", busy); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL hold after resp_valid: got %b expected 0", resp_valid); end
        if (req_ready !== 1'b1)  begin errors++; $display("FAIL hold after req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int lat, ivn, ivf, el;
        logic [63:0] d;
        for (int i = 0; i < 2; i++) begin
            el = exp_lat(3'd0, 64'd3, 64'd5);
            run_op(3'd0, 64'd3, 64'd5, lat, d, ivn, ivf);
            checks += 2;
            if (d !== 64'd15) begin errors++; $display("FAIL b2b[%0d] data: got %h expected %h", i, d, 64'd15); end
            if (lat !== el)   begin errors++; $display("FAIL b2b[%0d] latency: got %0d expected %0d", i, lat, el); end
            consume(3'd0, 64'd3, 64'd5);
        end
        checks++;
        if (lat !== (CACHE ? 1 : 67)) begin errors++; $display("FAIL b2b second latency: got %0d expected %0d", lat, CACHE ? 1 : 67); end
    endtask

    task automatic test_reset_mid();
        int w, lat, ivn, ivf;
        logic [63:0] d;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 64'd11; req_b = 64'd13;
        w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 6;
        if (resp_valid !== 1'b0)   begin errors++; $display("FAIL rst_mid resp_valid: got %b expected 0", resp_valid); end
        if (resp_data !== 64'd0)   begin errors++; $display("FAIL rst_mid resp_data: got %h expected 0", resp_data); end
        if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL rst_mid mul_in_valid: got %b expected 0", mul_in_valid); end
        if (mul_a !== 64'd0)       begin errors++; $display("FAIL rst_mid mul_a: got %h expected 0", mul_a); end
        if (mul_b !== 64'd0)       begin errors++; $display("FAIL rst_mid mul_b: got %h expected 0", mul_b); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        mc_valid = 1'b0;
        run_op(3'd0, 64'd3, 64'd5, lat, d, ivn, ivf);
        checks += 2;
        if (d !== 64'd15) begin errors++; $display("FAIL rst_mid next data: got %h expected %h", d, 64'd15); end
        if (lat !== 67)   begin errors++; $display("FAIL rst_mid next latency: got %0d expected 67", lat); end
        consume(3'd0, 64'd3, 64'd5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_flush_done();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
